// File: rtl/btn_event_pkg.sv
// Shared types and parameter defaults for the button event block.
// Contents: FSM state encoding, default hold/repeat periods, max helper.
// No ports; imported by button_events.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  // 1 s hold and 200 ms repeat at a 10 kHz clock
  localparam int HOLD_CYCLES_DEF   = 10000;
  localparam int REPEAT_CYCLES_DEF = 2000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Edge detector for a clean, clk-synchronous level.
// Ports: clk, reset_n (async active-low), level in; rise/fall combinational out.
// The previous-level register resets to 1 so a level held high through reset
// produces no rise until it has dropped and risen again.
module btn_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press/release/long-press/repeat
// pulses plus held/long_active levels; all outputs registered (1 cycle after edge).
// Ports: clk, reset_n (async active-low), btn_level in; pulse and level outputs.
// Optional macro BTN_EVENT_COUNT_EN adds press_count[7:0], a wrapping press counter.
module button_events
  import btn_event_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic       long_active
`ifdef BTN_EVENT_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, long_active_q;
  logic             rise, fall;

  btn_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (btn_level),
    .rise    (rise),
    .fall    (fall)
  );

  // PRESSED/LONG are only entered on a rise and only kept while the level is
  // high, so a low level in those states is always seen as a fall. Checking
  // the release first gives it priority over a coincident threshold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG: begin
        if (fall) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
      held_q        <= 1'b0;
      long_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
      release_q     <= release_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
      // levels track the state being entered so they line up with the pulses
      held_q        <= (state_d != IDLE);
      long_active_q <= (state_d == LONG);
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign long_active   = long_active_q;

`ifdef BTN_EVENT_COUNT_EN
  logic [7:0] press_count_q;

  // updates on the same edge that raises press_pulse; wraps naturally at 255
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_count_q <= 8'd0;
    end else if (press_d) begin
      press_count_q <= press_count_q + 8'd1;
    end
  end

  assign press_count = press_count_q;
`endif

endmodule

// File: tb/tb_button_events.sv
module tb_button_events;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_level = 1'b0;
  logic press_pulse, release_pulse, long_press, repeat_pulse, held, long_active;
`ifdef BTN_EVENT_COUNT_EN
  logic [7:0] press_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // observation vector: {press, release, long, repeat, held, long_active}
  logic [5:0] obs;
  assign obs = {press_pulse, release_pulse, long_press, repeat_pulse, held, long_active};

  localparam logic [5:0] ZERO  = 6'b000000;
  localparam logic [5:0] PRESS = 6'b100010;
  localparam logic [5:0] HELD  = 6'b000010;
  localparam logic [5:0] REL   = 6'b010000;
  localparam logic [5:0] LONGP = 6'b001011;
  localparam logic [5:0] LACT  = 6'b000011;
  localparam logic [5:0] REPT  = 6'b000111;

  button_events #(.HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .long_active   (long_active)
`ifdef BTN_EVENT_COUNT_EN
    ,
    .press_count   (press_count)
`endif
  );

  always #5 clk = ~clk;

  // advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn_level = 1'b0;
    #2;
    total_cnt++;
    if (obs !== ZERO) $display("FAIL reset_during: got %b expected %b", obs, ZERO);
    else pass_cnt++;
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total_cnt++;
      if (obs !== ZERO) $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs, ZERO);
      else pass_cnt++;
    end
  endtask

  task automatic test_short_press();
    logic [5:0] exp;
    btn_level = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = (i == 0) ? PRESS : HELD;
      total_cnt++;
      if (obs !== exp) $display("FAIL short_hold cyc %0d: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
    btn_level = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = (i == 0) ? REL : ZERO;
      total_cnt++;
      if (obs !== exp) $display("FAIL short_release cyc %0d: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_long_repeat();
    logic [5:0] exp;
    btn_level = 1'b1;
    tick();
    total_cnt++;
    if (obs !== PRESS) $display("FAIL long_press_start: got %b expected %b", obs, PRESS);
    else pass_cnt++;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i < 10)                 exp = HELD;
      else if (i == 10)           exp = LONGP;
      else if (i == 14 || i == 18) exp = REPT;
      else                        exp = LACT;
      total_cnt++;
      if (obs !== exp) $display("FAIL long_hold T+%0d: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
    btn_level = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = (i == 0) ? REL : ZERO;
      total_cnt++;
      if (obs !== exp) $display("FAIL long_release cyc %0d: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_release_at_threshold();
    logic [5:0] exp;
    btn_level = 1'b1;
    tick();
    total_cnt++;
    if (obs !== PRESS) $display("FAIL thr_press: got %b expected %b", obs, PRESS);
    else pass_cnt++;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total_cnt++;
      if (obs !== HELD) $display("FAIL thr_hold T+%0d: got %b expected %b", i, obs, HELD);
      else pass_cnt++;
    end
    // the next edge sees cnt==9 together with the low level
    btn_level = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = (i == 0) ? REL : ZERO;
      total_cnt++;
      if (obs !== exp) $display("FAIL thr_release cyc %0d: got %b expected %b", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_long();
    logic [5:0] exp;
    btn_level = 1'b1;
    tick();
    for (int i = 1; i <= 12; i++) tick();
    total_cnt++;
    if (obs !== LACT) $display("FAIL midlong_setup: got %b expected %b", obs, LACT);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (obs !== ZERO) $display("FAIL midlong_async: got %b expected %b", obs, ZERO);
    else pass_cnt++;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (obs !== ZERO) $display("FAIL held_thru_reset cyc %0d: got %b expected %b", i, obs, ZERO);
      else pass_cnt++;
    end
    btn_level = 1'b0;
    tick();
    total_cnt++;
    if (obs !== ZERO) $display("FAIL idle_fall: got %b expected %b", obs, ZERO);
    else pass_cnt++;
    btn_level = 1'b1;
    tick();
    total_cnt++;
    if (obs !== PRESS) $display("FAIL repress: got %b expected %b", obs, PRESS);
    else pass_cnt++;
    btn_level = 1'b0;
    tick();
    exp = REL;
    total_cnt++;
    if (obs !== exp) $display("FAIL repress_release: got %b expected %b", obs, exp);
    else pass_cnt++;
  endtask

  // release followed immediately by a new press, no idle gap
  task automatic test_back_to_back();
    btn_level = 1'b1;
    tick();
    btn_level = 1'b0;
    tick();
    total_cnt++;
    if (obs !== REL) $display("FAIL b2b_release: got %b expected %b", obs, REL);
    else pass_cnt++;
    btn_level = 1'b1;
    tick();
    total_cnt++;
    if (obs !== PRESS) $display("FAIL b2b_press: got %b expected %b", obs, PRESS);
    else pass_cnt++;
    btn_level = 1'b0;
    tick();
    tick();
  endtask

`ifdef BTN_EVENT_COUNT_EN
  task automatic test_press_count();
    reset_n = 1'b0;
    btn_level = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    total_cnt++;
    if (press_count !== 8'd0) $display("FAIL count_reset: got %0d expected 0", press_count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      btn_level = 1'b1;
      tick();
      btn_level = 1'b0;
      tick();
    end
    total_cnt++;
    if (press_count !== 8'd3) $display("FAIL count_three: got %0d expected 3", press_count);
    else pass_cnt++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      btn_level = 1'b1;
      tick();
      btn_level = 1'b0;
      tick();
      if (i == 254) begin
        total_cnt++;
        if (press_count !== 8'd255) $display("FAIL count_255: got %0d expected 255", press_count);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (press_count !== 8'd0) $display("FAIL count_wrap: got %0d expected 0", press_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_threshold();
    test_reset_mid_long();
    test_back_to_back();
`ifdef BTN_EVENT_COUNT_EN
    test_press_count();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
